// File: rtl/seven_seg_time_display.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_time_display
// Purpose  : Scanned 6-digit common-anode HH:MM:SS driver with frame snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_time_display #(
  parameter int CLK_FREQ_HZ  = 50_000,
  parameter int SCAN_FREQ_HZ = 1_000,
  parameter int SEC_VALUE    = 60,
  parameter int MIN_VALUE    = 60,
  parameter int HOUR_VALUE   = 24,
  parameter int LZ_BLANK     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(SEC_VALUE)-1:0]  in_sec,
  input  logic [$clog2(MIN_VALUE)-1:0]  in_min,
  input  logic [$clog2(HOUR_VALUE)-1:0] in_hour,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [5:0]                    an
);

  localparam int SEC_W  = $clog2(SEC_VALUE);
  localparam int MIN_W  = $clog2(MIN_VALUE);
  localparam int HOUR_W = $clog2(HOUR_VALUE);
  localparam int DIV    = CLK_FREQ_HZ / SCAN_FREQ_HZ;
  localparam int CNT_W  = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DIV - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'd5;
  localparam logic [6:0]       SEG_BLANK  = 7'h7F;
  localparam logic [6:0]       SEG_DASH   = 7'h3F;
  localparam logic [5:0]       AN_OFF     = 6'h3F;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'h40;
      4'd1:    digit_seg = 7'h79;
      4'd2:    digit_seg = 7'h24;
      4'd3:    digit_seg = 7'h30;
      4'd4:    digit_seg = 7'h19;
      4'd5:    digit_seg = 7'h12;
      4'd6:    digit_seg = 7'h02;
      4'd7:    digit_seg = 7'h78;
      4'd8:    digit_seg = 7'h00;
      4'd9:    digit_seg = 7'h10;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  logic              started_q,   started_d;
  logic [CNT_W-1:0]  div_cnt_q,   div_cnt_d;
  logic [2:0]        digit_idx_q, digit_idx_d;
  logic [SEC_W-1:0]  snap_sec_q,  snap_sec_d;
  logic [MIN_W-1:0]  snap_min_q,  snap_min_d;
  logic [HOUR_W-1:0] snap_hour_q, snap_hour_d;
  logic [6:0]        seg_q,       seg_d;
  logic              dp_q,        dp_d;
  logic [5:0]        an_q,        an_d;

  logic              frame_start;
  logic [7:0]        field_val;
  logic              field_bad;
  logic [3:0]        field_tens;
  logic [3:0]        field_ones;
  logic [3:0]        field_digit;

  // Scan counters and snapshot. The first edge out of reset re-enters the
  // slot 0 blank cycle instead of advancing, so that edge is a frame start.
  always_comb begin
    started_d   = 1'b1;
    div_cnt_d   = div_cnt_q;
    digit_idx_d = digit_idx_q;
    if (!started_q) begin
      div_cnt_d   = '0;
      digit_idx_d = '0;
    end else if (div_cnt_q == CNT_MAX) begin
      div_cnt_d   = '0;
      digit_idx_d = (digit_idx_q == LAST_DIGIT) ? 3'd0 : digit_idx_q + 3'd1;
    end else begin
      div_cnt_d   = div_cnt_q + 1'b1;
    end

    frame_start = (div_cnt_d == '0) && (digit_idx_d == 3'd0);
    snap_sec_d  = frame_start ? in_sec  : snap_sec_q;
    snap_min_d  = frame_start ? in_min  : snap_min_q;
    snap_hour_d = frame_start ? in_hour : snap_hour_q;
  end

  // Output decode works on next-state values so the registered outputs line
  // up with the counter registers.
  always_comb begin
    field_val = '0;
    field_bad = 1'b0;
    case (digit_idx_d)
      3'd0, 3'd1: begin
        field_val = 8'(snap_sec_d);
        field_bad = 32'(snap_sec_d) >= 32'(SEC_VALUE);
      end
      3'd2, 3'd3: begin
        field_val = 8'(snap_min_d);
        field_bad = 32'(snap_min_d) >= 32'(MIN_VALUE);
      end
      default: begin
        field_val = 8'(snap_hour_d);
        field_bad = 32'(snap_hour_d) >= 32'(HOUR_VALUE);
      end
    endcase
    field_tens  = 4'(field_val / 8'd10);
    field_ones  = 4'(field_val % 8'd10);
    field_digit = digit_idx_d[0] ? field_tens : field_ones;

    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if (div_cnt_d != '0) begin
      an_d = AN_OFF & ~(6'b000001 << digit_idx_d);
      if (field_bad) begin
        seg_d = SEG_DASH;
      end else if ((LZ_BLANK != 0) && (digit_idx_d == LAST_DIGIT) && (field_tens == 4'd0)) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = digit_seg(field_digit);
      end
      if ((digit_idx_d == 3'd2) || (digit_idx_d == 3'd4)) begin
        dp_d = snap_sec_d[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      started_q   <= 1'b0;
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= AN_OFF;
    end else begin
      started_q   <= started_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_time_display.sv
`default_nettype none
// Testbench for seven_seg_time_display: timeline-based reference model plus
// directed scenarios and randomized input traffic.
module tb_seven_seg_time_display;

  localparam int DIV   = 50;
  localparam int FRAME = 6 * DIV;
  localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] in_sec = '0;
  logic [5:0] in_min = '0;
  logic [4:0] in_hour = '0;
  logic [6:0] seg, seg_lz;
  logic       dp, dp_lz;
  logic [5:0] an, an_lz;

  int n_checks = 0;
  int n_pass = 0;

  // Reference timeline: t_m = cycles since reset release (-1 while in reset).
  int t_m = -1;
  int m_sec = 0, m_min = 0, m_hour = 0;

  always #5 clk = ~clk;

  seven_seg_time_display #(
    .CLK_FREQ_HZ(50_000), .SCAN_FREQ_HZ(1_000), .SEC_VALUE(60),
    .MIN_VALUE(60), .HOUR_VALUE(24), .LZ_BLANK(0)
  ) dut (
    .clk(clk), .reset(reset), .in_sec(in_sec), .in_min(in_min),
    .in_hour(in_hour), .seg(seg), .dp(dp), .an(an)
  );

  seven_seg_time_display #(
    .CLK_FREQ_HZ(50_000), .SCAN_FREQ_HZ(1_000), .SEC_VALUE(60),
    .MIN_VALUE(60), .HOUR_VALUE(24), .LZ_BLANK(1)
  ) dut_lz (
    .clk(clk), .reset(reset), .in_sec(in_sec), .in_min(in_min),
    .in_hour(in_hour), .seg(seg_lz), .dp(dp_lz), .an(an_lz)
  );

  always @(posedge clk) begin
    if (!reset) begin
      t_m    <= -1;
      m_sec  <= 0;
      m_min  <= 0;
      m_hour <= 0;
    end else begin
      t_m <= t_m + 1;
      if ((t_m + 1) % FRAME == 0) begin
        m_sec  <= int'(in_sec);
        m_min  <= int'(in_min);
        m_hour <= int'(in_hour);
      end
    end
  end

  // Expected {an, seg, dp} at timeline position t.
  function automatic logic [13:0] model_out(input int t, input bit lz);
    int pos, slot, v, md, d;
    logic [5:0] a;
    logic [6:0] s;
    logic p;
    if (t < 0) return {6'h3F, 7'h7F, 1'b1};
    pos  = t % DIV;
    slot = (t / DIV) % 6;
    if (pos == 0) return {6'h3F, 7'h7F, 1'b1};
    case (slot / 2)
      0:       begin v = m_sec;  md = 60; end
      1:       begin v = m_min;  md = 60; end
      default: begin v = m_hour; md = 24; end
    endcase
    d = (slot % 2 == 1) ? v / 10 : v % 10;
    if (v >= md) s = 7'h3F;
    else if (lz && slot == 5 && d == 0) s = 7'h7F;
    else s = SEG_TAB[d];
    a = 6'h3F;
    a[slot] = 1'b0;
    p = ((slot == 2) || (slot == 4)) ? ((m_sec % 2) != 0) : 1'b1;
    return {a, s, p};
  endfunction

  task automatic restart(input int h, input int m, input int s);
    @(negedge clk);
    reset   = 1'b0;
    in_hour = 5'(h);
    in_min  = 6'(m);
    in_sec  = 6'(s);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_hour = 5'd23; in_min = 6'd59; in_sec = 6'd58;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1})
        $display("FAIL reset cyc=%0d got an=%h seg=%h dp=%b exp an=3f seg=7f dp=1", i, an, seg, dp);
      else n_pass++;
    end
  endtask

  task automatic test_display();
    logic [6:0] es [0:5] = '{7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
    logic [5:0] ea [0:5] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [13:0] exp_v;
    int s;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp_v = model_out(t_m, 1'b0);
      n_checks++;
      if ({an, seg, dp} !== exp_v)
        $display("FAIL display t=%0d got=%h exp=%h", t_m, {an, seg, dp}, exp_v);
      else n_pass++;
      if (t_m == 0) begin
        n_checks++;
        if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1})
          $display("FAIL first_blank got an=%h seg=%h dp=%b exp an=3f seg=7f dp=1", an, seg, dp);
        else n_pass++;
      end
      if (t_m % DIV == DIV / 2) begin
        s = t_m / DIV;
        n_checks++;
        if (an !== ea[s] || seg !== es[s] || dp !== ((s == 2 || s == 4) ? 1'b0 : 1'b1))
          $display("FAIL display_slot%0d got an=%h seg=%h dp=%b exp an=%h seg=%h", s, an, seg, dp, ea[s], es[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_anti_tearing();
    logic [13:0] exp_v;
    restart(12, 34, 56);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      exp_v = model_out(t_m, 1'b0);
      n_checks++;
      if ({an, seg, dp} !== exp_v)
        $display("FAIL tearing t=%0d got=%h exp=%h", t_m, {an, seg, dp}, exp_v);
      else n_pass++;
      if (t_m == DIV / 2) begin
        n_checks++;
        if (seg !== 7'h02) $display("FAIL tear_f0_s0 got seg=%h exp 02", seg);
        else n_pass++;
      end
      if (t_m == 4 * DIV + DIV / 2) begin
        n_checks++;
        if (dp !== 1'b0) $display("FAIL tear_f0_s4_dp got dp=%b exp 0", dp);
        else n_pass++;
      end
      if (t_m == FRAME + DIV / 2) begin
        n_checks++;
        if (seg !== 7'h78) $display("FAIL tear_f1_s0 got seg=%h exp 78", seg);
        else n_pass++;
      end
      if (t_m == FRAME + 2 * DIV + DIV / 2 || t_m == FRAME + 4 * DIV + DIV / 2) begin
        n_checks++;
        if (dp !== 1'b1) $display("FAIL tear_f1_dp t=%0d got dp=%b exp 1", t_m, dp);
        else n_pass++;
      end
      if (t_m == 3 * DIV + 5) in_sec = 6'd57;
    end
  endtask

  task automatic test_out_of_range();
    logic [6:0] es [0:5] = '{7'h19, 7'h30, 7'h3F, 7'h3F, 7'h24, 7'h79};
    logic [13:0] exp_v;
    restart(12, 60, 34);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp_v = model_out(t_m, 1'b0);
      n_checks++;
      if ({an, seg, dp} !== exp_v)
        $display("FAIL range t=%0d got=%h exp=%h", t_m, {an, seg, dp}, exp_v);
      else n_pass++;
      if (t_m % DIV == DIV / 2) begin
        n_checks++;
        if (seg !== es[t_m / DIV])
          $display("FAIL range_slot%0d got seg=%h exp %h", t_m / DIV, seg, es[t_m / DIV]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_scan_timing();
    int blank_run, act_run, k, last_start;
    logic [5:0] exp_an;
    blank_run = 0; act_run = 0; k = 0; last_start = -1;
    restart(9, 8, 7);
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      @(negedge clk);
      if (an === 6'h3F) begin
        if (act_run > 0) begin
          n_checks++;
          if (act_run !== DIV - 1) $display("FAIL scan_active_len got %0d exp %0d", act_run, DIV - 1);
          else n_pass++;
        end
        act_run = 0;
        blank_run++;
      end else begin
        if (act_run == 0) begin
          exp_an = 6'h3F;
          exp_an[k] = 1'b0;
          n_checks++;
          if (blank_run !== 1 || an !== exp_an)
            $display("FAIL scan_slot_start got blanks=%0d an=%h exp blanks=1 an=%h", blank_run, an, exp_an);
          else n_pass++;
          if (k == 0) begin
            if (last_start >= 0) begin
              n_checks++;
              if (c - last_start !== FRAME) $display("FAIL scan_frame_len got %0d exp %0d", c - last_start, FRAME);
              else n_pass++;
            end
            last_start = c;
          end
          k = (k + 1) % 6;
        end
        blank_run = 0;
        act_run++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [13:0] exp_v;
    restart(12, 34, 56);
    for (int i = 0; i < FRAME && t_m != 3 * DIV + 10; i++) @(negedge clk);
    n_checks++;
    if (t_m !== 3 * DIV + 10) $display("FAIL midreset_reach got t=%0d exp %0d", t_m, 3 * DIV + 10);
    else n_pass++;
    reset = 1'b0; in_hour = 5'd23; in_min = 6'd59; in_sec = 6'd58;
    @(negedge clk);
    n_checks++;
    if ({an, seg, dp, an_lz, seg_lz, dp_lz} !== {6'h3F, 7'h7F, 1'b1, 6'h3F, 7'h7F, 1'b1})
      $display("FAIL midreset_outputs got an=%h seg=%h dp=%b exp an=3f seg=7f dp=1", an, seg, dp);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      exp_v = model_out(t_m, 1'b0);
      n_checks++;
      if ({an, seg, dp} !== exp_v)
        $display("FAIL midreset t=%0d got=%h exp=%h", t_m, {an, seg, dp}, exp_v);
      else n_pass++;
      if (t_m == DIV / 2) begin
        n_checks++;
        if (seg !== 7'h00 || an !== 6'h3E) $display("FAIL midreset_slot0 got an=%h seg=%h exp an=3e seg=00", an, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [13:0] exp_v, exp_lz;
    restart(7, 5, 9);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp_v  = model_out(t_m, 1'b0);
      exp_lz = model_out(t_m, 1'b1);
      n_checks++;
      if ({an, seg, dp} !== exp_v || {an_lz, seg_lz, dp_lz} !== exp_lz)
        $display("FAIL lz t=%0d got=%h/%h exp=%h/%h", t_m, {an, seg, dp}, {an_lz, seg_lz, dp_lz}, exp_v, exp_lz);
      else n_pass++;
      if (t_m == 5 * DIV + DIV / 2) begin
        n_checks++;
        if (seg_lz !== 7'h7F || an_lz !== 6'h1F || seg !== 7'h40)
          $display("FAIL lz_slot5 got lz seg=%h an=%h nolz seg=%h exp 7f 1f 40", seg_lz, an_lz, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_v, exp_lz;
    restart(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      exp_v  = model_out(t_m, 1'b0);
      exp_lz = model_out(t_m, 1'b1);
      n_checks++;
      if ({an, seg, dp} !== exp_v || {an_lz, seg_lz, dp_lz} !== exp_lz)
        $display("FAIL random t=%0d got=%h/%h exp=%h/%h", t_m, {an, seg, dp}, {an_lz, seg_lz, dp_lz}, exp_v, exp_lz);
      else n_pass++;
      if ($urandom_range(0, 99) < 3) begin
        in_sec  = 6'($urandom_range(0, 63));
        in_min  = 6'($urandom_range(0, 63));
        in_hour = 5'($urandom_range(0, 31));
      end
      reset = ($urandom_range(0, 399) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_anti_tearing();
    test_out_of_range();
    test_scan_timing();
    test_reset_mid_frame();
    test_lz_blank();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_time_display.md
# seven_seg_time_display

Scanned 6-digit seven-segment display driver placed directly downstream of `digital_clock`. It takes the `out_hour`/`out_min`/`out_sec` binary time values, converts each field to two decimal digits, and time-multiplexes them onto a common-anode display. Segments and anodes are active-low. A per-frame input snapshot prevents tearing, and each digit slot starts with a one-cycle blank to suppress ghosting.

## Interface
- `CLK_FREQ_HZ`, 50_000: system clock frequency.
- `SCAN_FREQ_HZ`, 1_000: digit slot rate. DIV = CLK_FREQ_HZ / SCAN_FREQ_HZ is the number of cycles per slot (integer division, must be ≥ 2; default 50).
- `SEC_VALUE`, 60: seconds modulus. Input width is $clog2(SEC_VALUE).
- `MIN_VALUE`, 60: minutes modulus. Input width is $clog2(MIN_VALUE).
- `HOUR_VALUE`, 24: hours modulus. Input width is $clog2(HOUR_VALUE).
- `LZ_BLANK`, 0: when 1, blank the hour-tens digit whenever it is 0.

Ports:
- `clk`  in  1  system clock; all logic uses the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `in_sec`  in  $clog2(SEC_VALUE)  seconds; driven by `digital_clock` `out_sec`.
- `in_min`  in  $clog2(MIN_VALUE)  minutes.
- `in_hour`  in  $clog2(HOUR_VALUE)  hours.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; used as the colon.
- `an`  out  6  digit enables, active-low, one-hot-low. Index mapping: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hour ones, 5 = hour tens.

## Operation
- Internal registers:
  - `div_cnt`: counts 0..DIV-1 and wraps.
  - `digit_idx`: 0..5. Advances by 1 on each `div_cnt` wrap; 5 → 0.
  - `snap`: holds sec, min and hour.
- Snapshot:
  - `snap` loads `in_*` on the edge where `digit_idx` becomes 0 with `div_cnt` = 0. That edge is the start of each frame, including the first edge after reset release.
  - `snap` holds its value for the whole frame.
- BCD conversion: tens = value / 10, ones = value % 10, computed from `snap`.
- Out-of-range field: if a snap field is ≥ its *_VALUE, both digits of that field show a dash (seg = 7'h3F).
- Segment codes (hex, active-low): 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10, blank = 7F.
- Leading-zero blank: with LZ_BLANK = 1 and hour tens = 0, slot 5 drives seg = 7F while `an[5]` stays low.
- Colon: during slots 2 and 4, `dp` = 0 when snap sec is even and 1 when it is odd. In every other slot, `dp` = 1.
- Blank cycle: the first cycle of every slot (`div_cnt` = 0) drives an = 6'h3F, seg = 7'h7F, dp = 1.
- Active cycles: cycles with `div_cnt` 1..DIV-1 drive `an[digit_idx]` low and all other anodes high; `seg`/`dp` carry that digit.
- All outputs are registered and decoded from next-state values, so they follow the register state above with no extra lag.

## Timing
- Reset values: an = 6'h3F, seg = 7'h7F, dp = 1, div_cnt = 0, digit_idx = 0, snap = 0.
- Reset takes effect on the first edge with reset = 0, including mid-frame. All state and outputs return to reset values on that edge.
- First cycle after release is the blank cycle of slot 0, with `snap` freshly loaded. Slot 0 digits appear on the second cycle after release.
- Slot lengths:
  - Slot = DIV cycles (1 blank + DIV-1 active).
  - Frame = 6 × DIV cycles (default 300 cycles = 6 ms at 50 kHz).
- Input latency: a change on `in_*` is displayed in the next frame. Worst case is 6 × DIV + 1 cycles.
- Inputs may change on any cycle. Only the value at the frame-start edge matters.

## Test plan
- Reset: hold reset = 0 for 5 cycles with inputs at 23:59:58 → an = 3F, seg = 7F, dp = 1 on every cycle.
- Display correctness: release reset with inputs 23:59:58. Expected per slot:
  - slot 0: seg = 00
  - slot 1: seg = 12
  - slot 2: seg = 10, dp = 0
  - slot 3: seg = 12
  - slot 4: seg = 30, dp = 0
  - slot 5: seg = 24
  - Anode for slots 0..5 is 3E, 3D, 3B, 37, 2F, 1F.
- Anti-tearing: start on 12:34:56 and change inputs to 12:34:57 during slot 3. The rest of that frame shows 56 with dp = 0. The next frame's slot 0 shows seg = 78, and slots 2 and 4 show dp = 1.
- Out-of-range: in_min = 60 → slots 2 and 3 show seg = 3F; the other slots are unaffected.
- Scan timing: over 2 frames, each slot is 1 blank cycle + 49 active cycles, digit_idx wraps 5 → 0, and the frame length is exactly 300 cycles.
- Reset mid-frame and LZ_BLANK: assert reset during slot 3 → outputs take reset values on the next edge; after release, slot 0 restarts with a new snapshot. With LZ_BLANK = 1 and hour = 7, slot 5 shows seg = 7F with an = 1F.
